clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Idle-detect clock-gating controller that drives the EN pin of a `user_clock_gate` cell for one downstream clock domain. It watches domain activity and gates the clock after a programmable run of idle cycles. It restarts the clock on activity, a wake request or an override, and reports when the domain is stably clocked again. It runs on the free-running (ungated) clock, next to the gate cell it controls.

## Interface
Parameters:
- `HYST_W`, 4: width of the idle-hysteresis config.
- `WAKE_LAT`, 2: cycles `clk_en` is held high before `domain_rdy` asserts; 0 allowed.
- `EVT_W`, 16: width of the gating-event counter.

Ports:
- `clk` in 1: free-running clock. One clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `busy_i` in 1: domain activity. High means not idle.
- `wake_req` in 1: level request to wake and hold the domain clocked.
- `force_on` in 1: override. While high, gating is inhibited.
- `hyst_cfg` in `HYST_W`: number of consecutive idle cycles before gating. 0 disables gating.
- `clk_en` out 1: registered enable to the gate cell EN.
- `domain_rdy` out 1: gated clock is running and stable.
- `gated_o` out 1: the clock is currently gated.
- `wake_ack` out 1: one-cycle acknowledge of `wake_req`.
- `gate_events` out `EVT_W`: saturating count of ACTIVE→GATED transitions.

## Operation
- An edge is "idle" when `busy_i`, `wake_req` and `force_on` are all 0 and `hyst_cfg` != 0.
- State machine has three states: ACTIVE, GATED and WAKING.
- **ACTIVE:** `clk_en`=1, `domain_rdy`=1, `gated_o`=0.
  - `idle_cnt` increments on each idle edge.
  - `idle_cnt` clears on any non-idle edge.
  - Go to GATED on an idle edge with `idle_cnt` >= `hyst_cfg`-1. The comparison uses the live `hyst_cfg`, so a mid-count decrease gates on the next idle edge.
  - Entering GATED clears `idle_cnt` and increments `gate_events`, saturating at all-ones.
- **GATED:** `clk_en`=0, `domain_rdy`=0, `gated_o`=1.
  - On an edge with any of `busy_i`, `wake_req`, `force_on` high: go to WAKING and load `wake_cnt`=`WAKE_LAT`.
  - If `WAKE_LAT`=0, go directly to ACTIVE instead.
  - `hyst_cfg` becoming 0 while GATED does not by itself wake the domain.
- **WAKING:** `clk_en`=1, `domain_rdy`=0, `gated_o`=0.
  - `wake_cnt` decrements each edge.
  - Go to ACTIVE on the edge where `wake_cnt`==1.
  - Inputs are ignored while WAKING; no re-gating is possible mid-wake.
- **wake_req handshake:**
  - `wake_req` rising while GATED or WAKING sets `wake_pend`.
  - `wake_ack` pulses in the first ACTIVE cycle when `wake_pend` is set; `wake_pend` then clears.
  - `wake_req` rising while ACTIVE produces a `wake_ack` pulse in the next cycle.
  - Requester holds `wake_req` until `wake_ack`. Holding it longer keeps the domain clocked, with no further acks.
  - `wake_req` dropping before ack while WAKING still yields the ack.
- **Reset:** state ACTIVE, `clk_en`=1, `domain_rdy`=1, `gated_o`=0, `wake_ack`=0, `gate_events`=0, counters 0.
  - Reset asserted while GATED forces `clk_en` high asynchronously.

## Timing
- All outputs are flops on `clk` posedge. There is no combinational input→output path.
- Gating latency: `clk_en` falls after the `hyst_cfg`-th consecutive idle edge. For `hyst_cfg`=1, it falls after the first.
- Wake latency:
  - `clk_en` rises 1 edge after the wake-cause edge.
  - `domain_rdy` rises `WAKE_LAT` edges after that.
  - `wake_ack` is coincident with the first `domain_rdy`=1 cycle.
- `clk_en` changes only at posedge. The gate cell samples EN on negedge, so there is half a cycle of setup and no glitch.
- Simultaneous last idle edge and `busy_i` rise: busy wins, and the block stays ACTIVE.

## Structure
- Package `clk_gate_pkg`:
  - `typedef enum logic [1:0] {CG_ACTIVE, CG_GATED, CG_WAKING} cg_state_e`.
  - Default localparams for `WAKE_LAT`, `HYST_W` and `EVT_W`.
- No sub-module. A single always_ff holds state, `idle_cnt`, `wake_cnt`, `wake_pend` and `gate_events`.
- Top-level integration instantiates this block beside `user_clock_gate`, with `clk_en`→EN.

## Test plan
- Idle run: `hyst_cfg`=3, `busy_i` low from edge 1.
  - Required: `clk_en`=0 after edge 3, `gated_o`=1, `gate_events`=1.
- Busy glitch: `hyst_cfg`=3, `busy_i` high at edge 2 of the idle run.
  - Required: no gating until 3 further idle edges; `idle_cnt` restarts.
- Wake handshake: GATED, `WAKE_LAT`=2, `wake_req` high at edge N.
  - Required: `clk_en`=1 after N+1, `domain_rdy`=1 and `wake_ack`=1 after N+3.
  - Then `wake_ack`=0 the next cycle.
- Disable and override: `hyst_cfg`=0 or `force_on`=1 with `busy_i`=0 for 50 cycles.
  - Required: `clk_en` stays 1, `gate_events` unchanged.
- Counter saturation and reset: `EVT_W`=2, five gating cycles.
  - Required: `gate_events`=3.
  - Then `rst` pulse while GATED: `clk_en`=1 immediately, all outputs at reset values.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and default parameters for the idle-detect clock-gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_ACTIVE = 2'd0,
        CG_GATED  = 2'd1,
        CG_WAKING = 2'd2
    } cg_state_e;

    localparam int CG_HYST_W_DEF   = 4;
    localparam int CG_WAKE_LAT_DEF = 2;
    localparam int CG_EVT_W_DEF    = 16;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller driving the EN pin of one gate cell.
// Runs on the free-running clock; all outputs are flops.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int HYST_W   = CG_HYST_W_DEF,
    parameter int WAKE_LAT = CG_WAKE_LAT_DEF,
    parameter int EVT_W    = CG_EVT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_i,
    input  logic              wake_req,
    input  logic              force_on,
    input  logic [HYST_W-1:0] hyst_cfg,
    output logic              clk_en,
    output logic              domain_rdy,
    output logic              gated_o,
    output logic              wake_ack,
    output logic [EVT_W-1:0]  gate_events
);

    localparam int WCW = (WAKE_LAT > 0) ? $clog2(WAKE_LAT + 1) : 1;

    cg_state_e         state_r;
    logic [HYST_W-1:0] idle_cnt_r;
    logic [WCW-1:0]    wake_cnt_r;
    logic              wake_pend_r;
    logic              wake_req_q_r;

    logic cause_s;
    logic idle_s;
    logic last_idle_s;
    logic rise_s;
    logic pend_s;
    logic evt_max_s;

    // Decode idle/wake causes and the wake_req rising edge.
    always_comb begin
        cause_s     = busy_i | wake_req | force_on;
        idle_s      = !cause_s && (hyst_cfg != {HYST_W{1'b0}});
        last_idle_s = idle_s && (idle_cnt_r >= (hyst_cfg - HYST_W'(1)));
        rise_s      = wake_req & ~wake_req_q_r;
        pend_s      = wake_pend_r | rise_s;
        evt_max_s   = &gate_events;
    end

    // State machine with counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= CG_ACTIVE;
            idle_cnt_r   <= {HYST_W{1'b0}};
            wake_cnt_r   <= {WCW{1'b0}};
            wake_pend_r  <= 1'b0;
            wake_req_q_r <= 1'b0;
            clk_en       <= 1'b1;
            domain_rdy   <= 1'b1;
            gated_o      <= 1'b0;
            wake_ack     <= 1'b0;
            gate_events  <= {EVT_W{1'b0}};
        end else begin
            wake_req_q_r <= wake_req;
            wake_ack     <= 1'b0;
            case (state_r)
                CG_ACTIVE: begin
                    wake_ack <= rise_s;
                    if (last_idle_s) begin
                        state_r    <= CG_GATED;
                        idle_cnt_r <= {HYST_W{1'b0}};
                        clk_en     <= 1'b0;
                        domain_rdy <= 1'b0;
                        gated_o    <= 1'b1;
                        if (!evt_max_s) begin
                            gate_events <= gate_events + EVT_W'(1);
                        end else begin
                            gate_events <= gate_events;
                        end
                    end else if (idle_s) begin
                        idle_cnt_r <= idle_cnt_r + HYST_W'(1);
                    end else begin
                        idle_cnt_r <= {HYST_W{1'b0}};
                    end
                end
                CG_GATED: begin
                    if (cause_s) begin
                        clk_en  <= 1'b1;
                        gated_o <= 1'b0;
                        if (WAKE_LAT == 0) begin
                            // No settle time: the ack goes out with the first ready cycle.
                            state_r     <= CG_ACTIVE;
                            domain_rdy  <= 1'b1;
                            wake_ack    <= pend_s;
                            wake_pend_r <= 1'b0;
                        end else begin
                            state_r     <= CG_WAKING;
                            wake_cnt_r  <= WCW'(WAKE_LAT);
                            wake_pend_r <= pend_s;
                        end
                    end else begin
                        wake_pend_r <= pend_s;
                    end
                end
                CG_WAKING: begin
                    if (wake_cnt_r == WCW'(1)) begin
                        state_r     <= CG_ACTIVE;
                        wake_cnt_r  <= {WCW{1'b0}};
                        domain_rdy  <= 1'b1;
                        wake_ack    <= pend_s;
                        wake_pend_r <= 1'b0;
                    end else begin
                        wake_cnt_r  <= wake_cnt_r - WCW'(1);
                        wake_pend_r <= pend_s;
                    end
                end
                default: begin
                    state_r     <= CG_ACTIVE;
                    idle_cnt_r  <= {HYST_W{1'b0}};
                    wake_cnt_r  <= {WCW{1'b0}};
                    wake_pend_r <= 1'b0;
                    clk_en      <= 1'b1;
                    domain_rdy  <= 1'b1;
                    gated_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: one instance with WAKE_LAT=2/EVT_W=2,
// plus a WAKE_LAT=0 instance on the same inputs for the zero-latency wake.
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       busy_i;
    logic       wake_req;
    logic       force_on;
    logic [3:0] hyst_cfg;

    logic       clk_en, domain_rdy, gated_o, wake_ack;
    logic [1:0] gate_events;
    logic       clk_en0, domain_rdy0, gated_o0, wake_ack0;
    logic [1:0] gate_events0;

    int n_checks;
    int n_errors;

    clk_gate_ctrl #(.HYST_W(4), .WAKE_LAT(2), .EVT_W(2)) u_dut (
        .clk(clk), .rst(rst), .busy_i(busy_i), .wake_req(wake_req),
        .force_on(force_on), .hyst_cfg(hyst_cfg), .clk_en(clk_en),
        .domain_rdy(domain_rdy), .gated_o(gated_o), .wake_ack(wake_ack),
        .gate_events(gate_events)
    );

    clk_gate_ctrl #(.HYST_W(4), .WAKE_LAT(0), .EVT_W(2)) u_dut_lat0 (
        .clk(clk), .rst(rst), .busy_i(busy_i), .wake_req(wake_req),
        .force_on(force_on), .hyst_cfg(hyst_cfg), .clk_en(clk_en0),
        .domain_rdy(domain_rdy0), .gated_o(gated_o0), .wake_ack(wake_ack0),
        .gate_events(gate_events0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wake the domain by busy and check it is ready after WAKE_LAT+1 edges.
    task automatic wake_by_busy(input string tag);
        busy_i = 1'b1;
        step();
        check_eq({tag, "_en"}, {31'd0, clk_en}, 32'd1);
        step();
        step();
        check_eq({tag, "_rdy"}, {31'd0, domain_rdy}, 32'd1);
        check_eq({tag, "_noack"}, {31'd0, wake_ack}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        busy_i   = 1'b1;
        wake_req = 1'b0;
        force_on = 1'b0;
        hyst_cfg = 4'd3;
        step();
        step();
        rst = 1'b0;
        step();

        check_eq("rst_en",  {31'd0, clk_en},     32'd1);
        check_eq("rst_rdy", {31'd0, domain_rdy}, 32'd1);
        check_eq("rst_gtd", {31'd0, gated_o},    32'd0);
        check_eq("rst_ack", {31'd0, wake_ack},   32'd0);
        check_eq("rst_evt", {30'd0, gate_events}, 32'd0);

        // Idle run, hyst_cfg=3
        busy_i = 1'b0;
        step();
        check_eq("idle_e1", {31'd0, clk_en}, 32'd1);
        step();
        check_eq("idle_e2", {31'd0, clk_en}, 32'd1);
        step();
        check_eq("idle_e3_en",  {31'd0, clk_en},  32'd0);
        check_eq("idle_e3_gtd", {31'd0, gated_o}, 32'd1);
        check_eq("idle_e3_rdy", {31'd0, domain_rdy}, 32'd0);
        check_eq("idle_e3_evt", {30'd0, gate_events}, 32'd1);
        check_eq("lat0_gtd",    {31'd0, gated_o0}, 32'd1);

        // Wake handshake
        wake_req = 1'b1;
        step();
        check_eq("wk1_en",  {31'd0, clk_en},     32'd1);
        check_eq("wk1_rdy", {31'd0, domain_rdy}, 32'd0);
        check_eq("wk1_gtd", {31'd0, gated_o},    32'd0);
        check_eq("wk1_ack", {31'd0, wake_ack},   32'd0);
        check_eq("lat0_wk1_rdy", {31'd0, domain_rdy0}, 32'd1);
        check_eq("lat0_wk1_ack", {31'd0, wake_ack0},   32'd1);
        step();
        check_eq("wk2_rdy", {31'd0, domain_rdy}, 32'd0);
        check_eq("wk2_ack", {31'd0, wake_ack},   32'd0);
        check_eq("lat0_wk2_ack", {31'd0, wake_ack0}, 32'd0);
        step();
        check_eq("wk3_rdy", {31'd0, domain_rdy}, 32'd1);
        check_eq("wk3_ack", {31'd0, wake_ack},   32'd1);
        step();
        check_eq("wk4_ack", {31'd0, wake_ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wk_hold_en",  {31'd0, clk_en},   32'd1);
            check_eq("wk_hold_ack", {31'd0, wake_ack}, 32'd0);
        end
        wake_req = 1'b0;
        busy_i   = 1'b1;
        step();

        // Busy glitch at the second idle edge restarts the count
        busy_i = 1'b0;
        step();
        busy_i = 1'b1;
        step();
        busy_i = 1'b0;
        step();
        check_eq("glitch_i1", {31'd0, clk_en}, 32'd1);
        step();
        check_eq("glitch_i2", {31'd0, clk_en}, 32'd1);
        step();
        check_eq("glitch_i3_en",  {31'd0, clk_en}, 32'd0);
        check_eq("glitch_i3_evt", {30'd0, gate_events}, 32'd2);

        // hyst_cfg dropping to 0 while gated does not wake
        hyst_cfg = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check_eq("hyst0_gated_en",  {31'd0, clk_en},  32'd0);
        check_eq("hyst0_gated_gtd", {31'd0, gated_o}, 32'd1);
        wake_by_busy("wake_a");

        // Gating disabled
        busy_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check_eq("dis_en", {31'd0, clk_en}, 32'd1);
        end
        check_eq("dis_evt", {30'd0, gate_events}, 32'd2);

        // Override
        hyst_cfg = 4'd3;
        force_on = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check_eq("ovr_en", {31'd0, clk_en}, 32'd1);
        end
        check_eq("ovr_evt", {30'd0, gate_events}, 32'd2);
        force_on = 1'b0;

        // Busy on the would-be last idle edge wins
        step();
        step();
        busy_i = 1'b1;
        step();
        check_eq("busywin_en",  {31'd0, clk_en},  32'd1);
        check_eq("busywin_gtd", {31'd0, gated_o}, 32'd0);
        busy_i = 1'b0;
        step();
        step();
        step();
        check_eq("g3_en",  {31'd0, clk_en}, 32'd0);
        check_eq("g3_evt", {30'd0, gate_events}, 32'd3);

        // Mid-count hyst decrease gates on the next idle edge; counter saturates
        wake_by_busy("wake_b");
        busy_i = 1'b0;
        step();
        check_eq("hdec_e1", {31'd0, clk_en}, 32'd1);
        hyst_cfg = 4'd1;
        step();
        check_eq("hdec_e2_en",  {31'd0, clk_en}, 32'd0);
        check_eq("g4_evt_sat",  {30'd0, gate_events}, 32'd3);

        wake_by_busy("wake_c");
        busy_i = 1'b0;
        step();
        check_eq("g5_en",      {31'd0, clk_en}, 32'd0);
        check_eq("g5_evt_sat", {30'd0, gate_events}, 32'd3);

        // Reset while gated: clk_en returns high without waiting for an edge
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_en",  {31'd0, clk_en},     32'd1);
        check_eq("arst_rdy", {31'd0, domain_rdy}, 32'd1);
        check_eq("arst_gtd", {31'd0, gated_o},    32'd0);
        check_eq("arst_ack", {31'd0, wake_ack},   32'd0);
        check_eq("arst_evt", {30'd0, gate_events}, 32'd0);
        busy_i = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("post_rst_en", {31'd0, clk_en}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
